// File: rtl/shift_fu_arbiter_pkg.sv
// Shared definitions for the shift functional unit front-end: opcode encodings,
// datapath widths and the operand bundle routed from the winning issue port.
package shift_fu_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    typedef struct packed {
        logic               op;
        logic [DATA_W-1:0]  a;
        logic [SHAMT_W-1:0] shamt;
    } shift_operand_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

    // Round-robin choice between two requesters; prio names the favoured port.
    function automatic logic pick_port(input logic v0, input logic v1, input logic prio);
        logic port;
        port = v1;
        if (v0 && v1) begin
            port = prio;
        end
        return port;
    endfunction

endpackage

// File: rtl/shift_fu_arbiter_shift_datapath.sv
// Combinational 32-bit shifter: log-stage left and arithmetic-right barrel
// shifters with a final 2:1 select on the opcode.
module shift_barrel_left
    import shift_fu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] stage [0:SHAMT_W];

    assign stage[0] = a;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        assign stage[i+1] = shamt[i] ? {stage[i][DATA_W-1-SH:0], {SH{1'b0}}} : stage[i];
    end

    assign result = stage[SHAMT_W];

endmodule

module shift_barrel_right_arith
    import shift_fu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] stage [0:SHAMT_W];

    assign stage[0] = a;

    // The sign bit never moves, so every stage may replicate stage[i]'s MSB.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        assign stage[i+1] = shamt[i] ? {{SH{stage[i][DATA_W-1]}}, stage[i][DATA_W-1:SH]}
                                     : stage[i];
    end

    assign result = stage[SHAMT_W];

endmodule

module shift_datapath
    import shift_fu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               op,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] sll_result;
    logic [DATA_W-1:0] sra_result;

    shift_barrel_left u_sll (
        .a      (a),
        .shamt  (shamt),
        .result (sll_result)
    );

    shift_barrel_right_arith u_sra (
        .a      (a),
        .shamt  (shamt),
        .result (sra_result)
    );

    assign result = (op == SHIFT_OP_SRA) ? sra_result : sll_result;

endmodule

// File: rtl/shift_fu_arbiter.sv
// Shift FU front-end: round-robin arbitration of two issue ports onto one shift
// datapath, with a single-entry valid/ready output register toward the CDB.
module shift_fu_arbiter
    import shift_fu_arbiter_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_op,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [TAG_W-1:0]   req0_tag,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_op,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [TAG_W-1:0]   req1_tag,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_src
);

    logic              prio_q,      prio_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic              out_src_q,   out_src_d;

    logic              grant_valid;
    logic              grant_port;
    logic              can_accept;
    logic              accept;
    shift_operand_t    sel_operand;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] shift_result;

    // NOTE: every signal written here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant_port  = pick_port(req0_valid, req1_valid, prio_q);
        // A draining result frees the stage in the same cycle, allowing pass-through.
        can_accept  = !out_valid_q || out_ready;
        // Nothing is taken from a requester while reset is held.
        accept      = grant_valid && can_accept && !reset;

        req0_ready  = accept && (grant_port == PORT_0);
        req1_ready  = accept && (grant_port == PORT_1);

        sel_operand = '{op: req0_op, a: req0_a, shamt: req0_shamt};
        sel_tag     = req0_tag;
        if (grant_port == PORT_1) begin
            sel_operand = '{op: req1_op, a: req1_a, shamt: req1_shamt};
            sel_tag     = req1_tag;
        end
    end

    shift_datapath u_datapath (
        .a      (sel_operand.a),
        .shamt  (sel_operand.shamt),
        .op     (sel_operand.op),
        .result (shift_result)
    );

    always_comb begin
        prio_d      = prio_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_src_d   = out_src_q;
        // Stay valid only while stalled; a drain with no new accept empties the stage.
        out_valid_d = out_valid_q && !out_ready;

        if (accept) begin
            prio_d      = ~grant_port;
            out_valid_d = 1'b1;
            out_data_d  = shift_result;
            out_tag_d   = sel_tag;
            out_src_d   = grant_port;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous and also discards any held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_src_q   <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_shift_fu_arbiter.sv
// Self-checking bench for shift_fu_arbiter: table-driven single-port shifts,
// round-robin fairness, stall/pass-through and reset-discard sequences.
module tb_shift_fu_arbiter;

    localparam int TAG_W = 6;

    logic             clock;
    logic             reset;
    logic             req0_valid, req0_ready, req0_op;
    logic [31:0]      req0_a;
    logic [4:0]       req0_shamt;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_op;
    logic [31:0]      req1_a;
    logic [4:0]       req1_shamt;
    logic [TAG_W-1:0] req1_tag;
    logic             out_valid, out_ready, out_src;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    shift_fu_arbiter #(.TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_src    (out_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_shift(input logic op, input logic [31:0] a,
                                                input logic [4:0] sh);
        if (op) return $unsigned($signed(a) >>> sh);
        return a << sh;
    endfunction

    // Scoreboard: pushed when a requester handshake completes, popped on CDB handshake.
    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] exp0_data, exp1_data;

    always @(negedge clock) begin
        sb_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_tag", out_tag, e.tag);
                    check("sb_src", out_src, e.src);
                end
            end
            if (req0_valid && req0_ready) sb.push_back('{exp0_data, req0_tag, 1'b0});
            if (req1_valid && req1_ready) sb.push_back('{exp1_data, req1_tag, 1'b1});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load0(input logic op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [TAG_W-1:0] tag);
        req0_op = op; req0_a = a; req0_shamt = sh; req0_tag = tag;
        exp0_data = model_shift(op, a, sh);
    endtask

    task automatic load1(input logic op, input logic [31:0] a, input logic [4:0] sh,
                         input logic [TAG_W-1:0] tag);
        req1_op = op; req1_a = a; req1_shamt = sh; req1_tag = tag;
        exp1_data = model_shift(op, a, sh);
    endtask

    typedef struct {
        logic             port;
        logic             op;
        logic [31:0]      a;
        logic [4:0]       sh;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[9];

    // Drives one operation on a single port; expected data comes from the table.
    task automatic send(input vec_t v);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        if (v.port) begin
            req1_op = v.op; req1_a = v.a; req1_shamt = v.sh; req1_tag = v.tag;
            exp1_data = v.exp; req1_valid = 1'b1;
        end else begin
            req0_op = v.op; req0_a = v.a; req0_shamt = v.sh; req0_tag = v.tag;
            exp0_data = v.exp; req0_valid = 1'b1;
        end
        while (!got && n < 20) begin
            @(negedge clock);
            got = v.port ? req1_ready : req0_ready;
            check("one_ready", req0_ready && req1_ready, 0);
            tick();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("send_accept", got, 1);
    endtask

    initial begin
        logic [31:0] hold_data;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0001, 5'd31, 6'd7,  32'h8000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h1234_ABCD, 5'd0,  6'd8,  32'h1234_ABCD};
        vecs[2] = '{1'b0, 1'b1, 32'h1234_ABCD, 5'd0,  6'd9,  32'h1234_ABCD};
        vecs[3] = '{1'b0, 1'b1, 32'h8000_0000, 5'd31, 6'd10, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 5'd31, 6'd11, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 5'd16, 6'd12, 32'hFFFF_0000};
        vecs[6] = '{1'b1, 1'b1, 32'hF000_0000, 5'd8,  6'd13, 32'hFFF0_0000};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_00F0, 5'd4,  6'd14, 32'h0000_0F00};
        vecs[8] = '{1'b1, 1'b1, 32'h4000_0000, 5'd30, 6'd15, 32'h0000_0001};

        // Reset held for two edges with port 0 already requesting.
        reset = 1'b1; out_ready = 1'b1;
        req1_valid = 1'b0; load1(1'b0, 32'h0, 5'd0, 6'd0);
        load0(1'b1, 32'h8000_0000, 5'd4, 6'd5);
        exp0_data = 32'hF800_0000;
        req0_valid = 1'b1;
        @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_src", out_src, 0);
        check("rst_req0_ready", req0_ready, 0);
        tick();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_req0_ready", req0_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        check("first_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        check("first_latency_valid", out_valid, 1);
        check("first_data", out_data, 32'hF800_0000);
        check("first_tag", out_tag, 5);
        tick();

        for (int i = 0; i < 9; i++) send(vecs[i]);
        tick();
        tick();

        // Fairness from reset: both ports busy, grants must alternate 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load0(1'b1, $urandom, 5'($urandom_range(0, 31)), 6'd20);
        load1(1'b0, $urandom, 5'($urandom_range(0, 31)), 6'd21);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("fair_rdy0", req0_ready, (i % 2) == 0);
            check("fair_rdy1", req1_ready, (i % 2) == 1);
            tick();
            if (i % 2 == 0) load0(1'b0, $urandom, 5'($urandom_range(0, 31)), 6'(22 + i));
            else            load1(1'b1, $urandom, 5'($urandom_range(0, 31)), 6'(22 + i));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        // Stall with both requesters waiting, then pass-through on release.
        out_ready = 1'b0;
        load0(1'b1, 32'h8765_4321, 5'd7, 6'd40);
        load1(1'b0, 32'h0F0F_0F0F, 5'd3, 6'd41);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clock);
        check("stall_acc0", req0_ready, 1);
        check("stall_acc1", req1_ready, 0);
        hold_data = exp0_data;
        tick();
        load0(1'b0, 32'hDEAD_BEEF, 5'd12, 6'd42);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall_valid", out_valid, 1);
            check("stall_rdy0", req0_ready, 0);
            check("stall_rdy1", req1_ready, 0);
            check("stall_data", out_data, hold_data);
            check("stall_tag", out_tag, 40);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("release_rdy1", req1_ready, 1);
        check("release_rdy0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        @(negedge clock);
        check("nogap_valid", out_valid, 1);
        check("nogap_src", out_src, 1);
        check("nogap_tag", out_tag, 41);
        check("nogap_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        check("last_tag", out_tag, 42);
        tick();
        tick();

        // Reset while a result is held: it must be discarded, not delivered.
        out_ready = 1'b0;
        load0(1'b0, 32'h1357_9BDF, 5'd1, 6'd50);
        req0_valid = 1'b1;
        @(negedge clock);
        check("hold_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        check("hold_valid", out_valid, 1);
        tick();
        reset = 1'b1;
        load1(1'b1, 32'h2468_ACE0, 5'd2, 6'd51);
        req1_valid = 1'b1;
        @(negedge clock);
        check("rstmid_rdy0", req0_ready, 0);
        check("rstmid_rdy1", req1_ready, 0);
        tick();
        reset = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data", out_data, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("rstmid_no_replay", out_valid, 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_fu_arbiter.md
Name: shift_fu_arbiter

Overview:
- Shift functional unit front-end for the out-of-order core.
- Arbitrates round-robin between two issue ports that share one combinational 32-bit shift datapath (SLL and SRA).
- Registers the result with its ROB tag, and holds it until the CDB accepts it via a valid/ready handshake.
- Single-entry output stage; accepted operations always complete with 1-cycle latency.

Parameters:
- TAG_W, 6, width of the ROB tag carried with each operation

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 has an operation
- req0_ready  output  1  port 0 operation accepted this cycle
- req0_op  input  1  0 = SLL, 1 = SRA
- req0_a  input  32  operand
- req0_shamt  input  5  shift amount
- req0_tag  input  TAG_W  ROB tag
- req1_valid, req1_ready, req1_op, req1_a, req1_shamt, req1_tag: identical to port 0, for port 1
- out_valid  output  1  registered result present
- out_ready  input  1  CDB takes result this cycle
- out_data  output  32  shifted result
- out_tag  output  TAG_W  tag of result
- out_src  output  1  issue port that produced the result

Behaviour:
- Reset values: out_valid=0, out_data=0, out_tag=0, out_src=0, priority pointer prio=0.
- Reset mid-operation: a held, unaccepted result is discarded; no req ready asserted during the reset cycle.
- Capacity: can_accept = !out_valid || out_ready. Pass-through in the same cycle the old result drains is allowed.
- Grant, combinational:
  - Both valid: grant port prio.
  - One valid: grant that port.
  - None valid: no grant.
- reqN_ready = grantN && can_accept; never asserted without the matching reqN_valid. At most one ready per cycle.
- prio update: on an accepted grant, prio <= ~granted_port. With no accept, prio holds.
- Fairness: under continuous dual requests with out_ready=1, grants alternate 0,1,0,1...
- Datapath: the granted port's op/a/shamt is muxed into shift_datapath.
  - SLL fills zeros.
  - SRA replicates bit 31.
  - shamt=0 passes a unchanged.
  - shamt=31 with SRA yields all sign bits.
- On accept: out_data, out_tag and out_src are loaded; out_valid <= 1 on the next edge. Latency is exactly 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready && no accept -> out_valid <= 0. Data and tag hold their last values.
- Stall: out_valid && !out_ready -> out_data, out_tag and out_src stay stable; both req ready = 0.
- Requester rules:
  - Requesters hold valid and payload until ready.
  - The block never drops or duplicates an operation; the tag always matches its own data.
- Output registers are the only sequential state besides prio. There is no other buffering.

Decomposition:
- shared package:
  - SHIFT_OP_SLL=1'b0, SHIFT_OP_SRA=1'b1
  - the data width constant 32
  - the shamt width constant 5
- sub-module shift_datapath:
  - purely combinational.
  - inputs a, shamt, op; output result.
  - instantiates the existing left and right barrel shifters and a 2:1 mux on op.
- The top module holds the arbiter, prio flop and output register.

Test Plan:
- Reset held 2 cycles with req0_valid=1 -> out_valid=0, out_data=0, req0_ready=0. After release, accept on the first cycle.
- req0 SRA a=0x80000000 shamt=4 tag=5, out_ready=1 -> next cycle out_valid=1, out_data=0xF8000000, out_tag=5, out_src=0.
- req1 SLL a=0x00000001 shamt=31 -> out_data=0x80000000. Same with shamt=0 and a=0x1234ABCD -> out_data=0x1234ABCD.
- Both ports valid continuously for 4 cycles, out_ready=1, from reset -> out_src sequence 0,1,0,1; each tag appears exactly once in order.
- Result held with out_ready=0 for 3 cycles while both requests valid -> output stable, req0_ready=req1_ready=0. On out_ready=1, the new result follows on the next cycle with no gap.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0. The held result never appears on the CDB.
